// File: rtl/mips_pipe_pkg.sv
// Shared pipeline encodings for the MIPS core.
// Branch ops, branch-resolve FSM states and bus width.
package mips_pipe_pkg;

  localparam int CPU_BUS_SIZE = 32;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5,
    BR_BGEZ = 3'd6,
    BR_RSVD = 3'd7
  } br_op_e;

  typedef enum logic {
    BRS_IDLE = 1'b0,
    BRS_WAIT = 1'b1
  } brs_state_e;

endpackage

// File: rtl/operand_fwd_mux.sv
// Per-operand forwarding select: EX > MEM > WB > RF.
// Flags a load-use hazard when a load in EX targets the index.
module operand_fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              i_use,
  input  logic [REG_AW-1:0] i_idx,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_ex_reg_write,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [DATA_W-1:0] i_ex_result,
  input  logic              i_mem_reg_write,
  input  logic              i_mem_mem_read,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_alu_result,
  input  logic [DATA_W-1:0] i_mem_read_data,
  input  logic              i_wb_reg_write,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_hazard
);

  logic w_fwd_ok;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  // r0 is hardwired, so it never takes a forwarded value
  assign w_fwd_ok  = i_use && (i_idx != '0);
  assign w_ex_hit  = w_fwd_ok && i_ex_reg_write && (i_ex_rd == i_idx);
  assign w_mem_hit = w_fwd_ok && i_mem_reg_write && (i_mem_rd == i_idx);
  assign w_wb_hit  = w_fwd_ok && i_wb_reg_write && (i_wb_rd == i_idx);

  always_comb begin
    o_data   = i_rf_data;
    o_hazard = 1'b0;
    if (w_ex_hit) begin
      if (i_ex_mem_read) o_hazard = 1'b1;
      else               o_data   = i_ex_result;
    end else if (w_mem_hit) begin
      o_data = i_mem_mem_read ? i_mem_read_data : i_mem_alu_result;
    end else if (w_wb_hit) begin
      o_data = i_wb_data;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution with forwarding and load-use stall.
// Registers a one-cycle taken/not-taken pulse per resolved branch.
module branch_resolve_unit
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W = CPU_BUS_SIZE,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [2:0]        id_branch_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_result,
  input  logic              mem_reg_write,
  input  logic              mem_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              resolve_valid,
  output logic              branch_taken,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  branch_count
);

  brs_state_e        r_state;
  logic              w_op_ok;
  logic              w_use_b;
  logic              w_active;
  logic              w_cond;
  logic              w_hazard;
  logic              w_resolve;
  logic              w_haz_a;
  logic              w_haz_b;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic              w_a_neg;
  logic              w_a_zero;

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
    .i_use            (w_active),
    .i_idx            (id_rs),
    .i_rf_data        (rf_data1),
    .i_ex_reg_write   (ex_reg_write),
    .i_ex_mem_read    (ex_mem_read),
    .i_ex_rd          (ex_rd),
    .i_ex_result      (ex_result),
    .i_mem_reg_write  (mem_reg_write),
    .i_mem_mem_read   (mem_mem_read),
    .i_mem_rd         (mem_rd),
    .i_mem_alu_result (mem_alu_result),
    .i_mem_read_data  (mem_read_data),
    .i_wb_reg_write   (wb_reg_write),
    .i_wb_rd          (wb_rd),
    .i_wb_data        (wb_data),
    .o_data           (w_a),
    .o_hazard         (w_haz_a)
  );

  operand_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
    .i_use            (w_active && w_use_b),
    .i_idx            (id_rt),
    .i_rf_data        (rf_data2),
    .i_ex_reg_write   (ex_reg_write),
    .i_ex_mem_read    (ex_mem_read),
    .i_ex_rd          (ex_rd),
    .i_ex_result      (ex_result),
    .i_mem_reg_write  (mem_reg_write),
    .i_mem_mem_read   (mem_mem_read),
    .i_mem_rd         (mem_rd),
    .i_mem_alu_result (mem_alu_result),
    .i_mem_read_data  (mem_read_data),
    .i_wb_reg_write   (wb_reg_write),
    .i_wb_rd          (wb_rd),
    .i_wb_data        (wb_data),
    .o_data           (w_b),
    .o_hazard         (w_haz_b)
  );

  assign w_a_neg  = w_a[DATA_W-1];
  assign w_a_zero = (w_a == '0);

  always_comb begin
    w_op_ok = 1'b1;
    w_use_b = 1'b0;
    w_cond  = 1'b0;
    unique case (br_op_e'(id_branch_op))
      BR_BEQ:  begin w_use_b = 1'b1; w_cond = (w_a == w_b); end
      BR_BNE:  begin w_use_b = 1'b1; w_cond = (w_a != w_b); end
      BR_BLEZ: w_cond = w_a_neg || w_a_zero;
      BR_BGTZ: w_cond = !w_a_neg && !w_a_zero;
      BR_BLTZ: w_cond = w_a_neg;
      BR_BGEZ: w_cond = !w_a_neg;
      default: w_op_ok = 1'b0;
    endcase
  end

  assign w_active  = id_valid && w_op_ok;
  assign w_hazard  = w_haz_a || w_haz_b;
  assign w_resolve = w_active && !w_hazard;
  assign stall     = !reset && w_active && w_hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= BRS_IDLE;
      resolve_valid <= 1'b0;
      branch_taken  <= 1'b0;
      stall_cycles  <= '0;
      branch_count  <= '0;
    end else begin
      resolve_valid <= w_resolve;
      branch_taken  <= w_resolve && w_cond;
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (w_resolve && (branch_count != '1))
        branch_count <= branch_count + CNT_W'(1);
      // squash or cleared hazard both leave WAIT
      unique case (r_state)
        BRS_IDLE: if (w_active && w_hazard) r_state <= BRS_WAIT;
        BRS_WAIT: if (!w_active || !w_hazard) r_state <= BRS_IDLE;
        default:  r_state <= BRS_IDLE;
      endcase
    end
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised ID-stage branch resolution unit for the pipelined MIPS core. It supersedes the single-width equality forwarder. It forwards operands from EX, MEM and WB with fixed priority, and stalls through load-use hazards with a small state machine. It evaluates six MIPS branch conditions and registers a one-cycle taken/not-taken decision toward the PC-select and IF/ID-flush logic.

## Interface
Parameters:
- `DATA_W`, 32: operand width; equals `CPU_BUS_SIZE`.
- `REG_AW`, 5: register-index width.
- `CNT_W`, 16: width of the saturating performance counters.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `id_valid`  in  1  IF/ID holds a valid instruction.
- `id_branch_op`  in  3  0 none, 1 beq, 2 bne, 3 blez, 4 bgtz, 5 bltz, 6 bgez, 7 reserved (treated as none).
- `id_rs`, `id_rt`  in  REG_AW  source indices.
- `rf_data1`, `rf_data2`  in  DATA_W  register-file read data.
- `ex_reg_write`, `ex_mem_read`  in  1  ID/EX control.
- `ex_rd`  in  REG_AW  and `ex_result`  in  DATA_W  ID/EX destination and ALU result.
- `mem_reg_write`, `mem_mem_read`  in  1  EX/MEM control.
- `mem_rd`  in  REG_AW  EX/MEM destination.
- `mem_alu_result`, `mem_read_data`  in  DATA_W  EX/MEM data.
- `wb_reg_write`  in  1, `wb_rd`  in  REG_AW, `wb_data`  in  DATA_W  MEM/WB write-back.
- `stall`  out  1  combinational; freezes PC and IF/ID, bubbles ID/EX.
- `resolve_valid`  out  1  registered pulse: a branch was resolved last cycle.
- `branch_taken`  out  1  registered; meaningful only when `resolve_valid` is high.
- `stall_cycles`, `branch_count`  out  CNT_W  saturating counters.

## Operation
Operand select, applied independently for rs (A) and rt (B):
- Index 0 never forwards; it reads `rf_data`, which is 0.
- Priority is EX > MEM > WB > register file, on a match of `*_reg_write` and `*_rd == index`.
- An EX match with `ex_mem_read` set is a hazard and the operand is unavailable.
- An EX match without `ex_mem_read` forwards `ex_result`.
- A MEM match forwards `mem_read_data` if `mem_mem_read` is set, else `mem_alu_result`. This applies to both operands.
- A WB match forwards `wb_data`.
- B-dependence applies only to beq/bne. Ops 3–6 ignore rt for hazards and forwarding.

Conditions, treating A as signed DATA_W-bit:
- beq: A==B. bne: A!=B.
- blez: A<=0. bgtz: A>0. bltz: A[MSB]. bgez: !A[MSB].

A branch is active when `id_valid` is high and `id_branch_op` is in 1..6.

`stall` = branch active AND a required operand is hazarded.

FSM:
- IDLE: a branch that is active and not stalled resolves and stays in IDLE. An active, stalled branch moves to WAIT.
- WAIT: `stall` is held while the hazard persists. When the hazard clears, the branch resolves and the FSM returns to IDLE. If the branch becomes inactive (squashed), the FSM returns to IDLE with no resolve.
- A load in EX becomes a MEM forward next cycle, so WAIT lasts exactly 1 cycle under legal pipeline behaviour. No timeout is imposed.

On the resolve cycle:
- `resolve_valid` and `branch_taken` are registered to 1 and the condition result respectively.
- `branch_count` increments, saturating at all-ones.

`stall_cycles` increments each cycle `stall` is high, saturating.

## Timing
- Reset values: state IDLE, `resolve_valid` 0, `branch_taken` 0, both counters 0. `stall` is 0 while reset is held.
- `stall` responds combinationally in the same cycle.
- Decision latency: `resolve_valid` is high in the cycle after resolution, for exactly 1 cycle per branch. Back-to-back branches give consecutive pulses.
- Reset asserted mid-WAIT abandons the branch with no pulse.
- Counters at the all-ones value hold there.
- If EX and MEM both match, EX wins. If EX is a load, the result is a stall even when MEM also matches.
- Reserved op 7 behaves as no branch: no stall and no resolve.

## Structure
- Shared package `mips_pipe_pkg` holds the branch-op encodings (`BR_NONE`..`BR_BGEZ`), the FSM state constants (`BRS_IDLE`, `BRS_WAIT`) and the default `CPU_BUS_SIZE`.
- One sub-module, `operand_fwd_mux`, performs the per-operand priority select and hazard flag. It is instantiated twice, for A and B.

## Test plan
- No hazards, `rf_data1=5`, `rf_data2=5`, beq → `stall` 0; next cycle `resolve_valid=1`, `branch_taken=1`. Repeat with bne → taken 0.
- `ex_rd=rs=8`, `ex_reg_write=1`, `ex_result=7`, `rf_data1=3`, `rf_data2=7`, beq → taken 1 (EX forward beats the stale register file).
- Load in EX to rt=9 → `stall` 1 for one cycle; next cycle MEM load with `mem_read_data=0x10` and A=0x10 → resolve, taken 1; `stall_cycles=1`.
- `ex_rd=mem_rd=4`, both writing, rs=4: `ex_result=1`, `mem_alu_result=2`, `rf_data2=1`, beq → taken 1 (EX priority). Also rs=0 with `ex_rd=0` → no forward.
- A=0x8000_0000: bltz → 1, bgez → 0, blez → 1, bgtz → 0. A=0: blez → 1, bgtz → 0.
- Assert `reset` during WAIT → `resolve_valid` 0, state IDLE. Force 2^CNT_W+3 stall cycles → `stall_cycles` saturates at all-ones.
